// File: rtl/muxm_pipe_pkg.sv
// Shared types and defaults for the registered N-way operand mux.
// The state encoding and the ready/valid decode live here so every user agrees on them.
package muxm_pipe_pkg;

    localparam int MUXM_DW    = 16;
    localparam int MUXM_N     = 4;
    localparam int CLK_PERIOD = 10;

    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_ONE   = 2'd1,
        MS_FULL  = 2'd2
    } muxm_state_t;

    function automatic logic state_valid(input muxm_state_t s);
        return (s != MS_EMPTY);
    endfunction

    function automatic logic state_ready(input muxm_state_t s);
        return (s != MS_FULL);
    endfunction

endpackage

// File: rtl/muxm_pipe_if.sv
// Upstream select/data handshake and downstream result handshake of muxm_pipe.
// The master modport is the side that drives operands and consumes the result.
interface muxm_pipe_if
    import muxm_pipe_pkg::*;
#(
    parameter int DW = MUXM_DW,
    parameter int N  = MUXM_N
) ();
    localparam int SW = $clog2(N);

    logic [SW-1:0]   sel_in;
    logic [N*DW-1:0] d_in;
    logic            valid_in;
    logic            ready_out;
    logic [DW-1:0]   m_out;
    logic            valid_out;
    logic            ready_in;
    logic            sel_err_out;

    modport master (
        output sel_in, d_in, valid_in, ready_in,
        input  ready_out, m_out, valid_out, sel_err_out
    );

    modport slave (
        input  sel_in, d_in, valid_in, ready_in,
        output ready_out, m_out, valid_out, sel_err_out
    );
endinterface

// File: rtl/muxm_pipe_skid.sv
// Generic 2-entry skid register: a main output register plus one spare slot, so
// ready_out can be a flop while still sustaining one transfer per cycle.
module muxm_pipe_skid
    import muxm_pipe_pkg::*;
#(
    parameter int DW = MUXM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);
    muxm_state_t   state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          valid_q;
    logic          ready_q;
    logic          acc_s;
    logic          xfer_s;

    // Next-state and data steering; order is main first, skid second.
    always_comb begin
        acc_s   = in_valid & ready_q;
        xfer_s  = valid_q & out_ready;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            MS_EMPTY: begin
                if (acc_s) begin
                    main_d  = in_data;
                    state_d = MS_ONE;
                end else begin
                    state_d = MS_EMPTY;
                end
            end
            MS_ONE: begin
                if (acc_s && xfer_s) begin
                    main_d  = in_data;
                    state_d = MS_ONE;
                end else if (acc_s) begin
                    skid_d  = in_data;
                    state_d = MS_FULL;
                end else if (xfer_s) begin
                    state_d = MS_EMPTY;
                end else begin
                    state_d = MS_ONE;
                end
            end
            MS_FULL: begin
                // ready_q is low here, so only the drain of main can happen.
                if (xfer_s) begin
                    main_d  = skid_q;
                    state_d = MS_ONE;
                end else begin
                    state_d = MS_FULL;
                end
            end
            default: begin
                state_d = MS_EMPTY;
            end
        endcase
    end

    // State, storage and the registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MS_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= state_valid(state_d);
            ready_q <= state_ready(state_d);
        end
    end

    assign in_ready  = ready_q;
    assign out_data  = main_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/muxm_pipe.sv
// Registered N-way operand mux with valid/ready handshake and a sticky flag for
// selects that do not name an input; out-of-range selects forward zero.
module muxm_pipe
    import muxm_pipe_pkg::*;
#(
    parameter int DW = MUXM_DW,
    parameter int N  = MUXM_N
) (
    input  logic       clk,
    input  logic       rst,
    muxm_pipe_if.slave bus
);
    localparam int SW = $clog2(N);

    logic [DW-1:0] sel_data_s;
    logic          sel_hit_s;
    logic          acc_s;
    logic          sel_err_d;
    logic          sel_err_q;

    // Decode the select; no hit means the select is out of range and data stays zero.
    always_comb begin
        sel_data_s = '0;
        sel_hit_s  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (bus.sel_in == SW'(k)) begin
                sel_data_s = bus.d_in[k*DW +: DW];
                sel_hit_s  = 1'b1;
            end else begin
                sel_hit_s  = sel_hit_s;
            end
        end
        acc_s     = bus.valid_in & bus.ready_out;
        sel_err_d = sel_err_q | (acc_s & ~sel_hit_s);
    end

    // Sticky range-error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.sel_err_out = sel_err_q;

    muxm_pipe_skid #(.DW(DW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (sel_data_s),
        .in_valid  (bus.valid_in),
        .in_ready  (bus.ready_out),
        .out_data  (bus.m_out),
        .out_valid (bus.valid_out),
        .out_ready (bus.ready_in)
    );

endmodule

// File: tb/tb_muxm_pipe.sv
// Self-checking bench for muxm_pipe (DW=16, N=3) against a queue-based reference model.
module tb_muxm_pipe;
    import muxm_pipe_pkg::*;

    localparam int DW = 16;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    muxm_pipe_if #(.DW(DW), .N(NI)) bus ();

    muxm_pipe #(.DW(DW), .N(NI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: items in flight (FIFO of depth 2) and the sticky error.
    logic [DW-1:0] mq[$];
    bit            err_m;

    function automatic logic [DW-1:0] pick(input logic [1:0] s, input logic [NI*DW-1:0] d);
        logic [NI*DW-1:0] sh;
        if (int'(s) >= NI) return '0;
        sh = d >> (DW * int'(s));
        return sh[DW-1:0];
    endfunction

    // Advance one clock, updating the model with what the edge should do.
    task automatic step();
        bit acc;
        bit xfer;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            err_m = 1'b0;
        end else begin
            acc  = bus.valid_in && (mq.size() < 2);
            xfer = (mq.size() > 0) && bus.ready_in;
            if (xfer) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(pick(bus.sel_in, bus.d_in));
                if (int'(bus.sel_in) >= NI) err_m = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.valid_in = 1'b1; bus.ready_in = 1'b1;
        bus.sel_in = 2'd1; bus.d_in = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        step(); step();
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus.valid_out); end
        total++; if (bus.m_out !== 16'h0000) begin bad++; $display("FAIL reset_mout: got %h want 0000", bus.m_out); end
        total++; if (bus.ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", bus.ready_out); end
        total++; if (bus.sel_err_out !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", bus.sel_err_out); end
        rst = 1'b0; bus.valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_quiet[%0d]: valid_out got %0b want 0", i, bus.valid_out); end
        end
    endtask

    task automatic test_stream();
        bus.ready_in = 1'b1; bus.valid_in = 1'b1;
        bus.d_in = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        for (int i = 0; i < 3; i++) begin
            bus.sel_in = 2'(i);
            step();
            total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, bus.valid_out); end
            total++; if (bus.m_out !== 16'(16'h0A0A + i * 16'h0101)) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, bus.m_out, 16'(16'h0A0A + i * 16'h0101)); end
        end
        bus.valid_in = 1'b0;
        step();
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL stream_end: valid_out got %0b want 0", bus.valid_out); end
    endtask

    task automatic test_backpressure();
        bus.ready_in = 1'b0; bus.valid_in = 1'b1;
        bus.d_in = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        bus.sel_in = 2'd0; step();
        total++; if (bus.ready_out !== 1'b1) begin bad++; $display("FAIL bp_ready1: got %0b want 1", bus.ready_out); end
        bus.sel_in = 2'd1; step();
        total++; if (bus.ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready2: got %0b want 0", bus.ready_out); end
        bus.sel_in = 2'd2; step();
        total++; if (bus.ready_out !== 1'b0 || bus.m_out !== 16'h0A0A) begin bad++; $display("FAIL bp_full: ready %0b m_out %h want 0 0a0a", bus.ready_out, bus.m_out); end
        bus.ready_in = 1'b1; step();
        total++; if (bus.m_out !== 16'h0B0B || bus.valid_out !== 1'b1) begin bad++; $display("FAIL bp_second: got %h/%0b want 0b0b/1", bus.m_out, bus.valid_out); end
        total++; if (bus.ready_out !== 1'b1) begin bad++; $display("FAIL bp_reopen: got %0b want 1", bus.ready_out); end
        step();
        total++; if (bus.m_out !== 16'h0C0C || bus.valid_out !== 1'b1) begin bad++; $display("FAIL bp_third: got %h/%0b want 0c0c/1", bus.m_out, bus.valid_out); end
        bus.valid_in = 1'b0; step();
        total++; if (bus.valid_out !== 1'b0 || mq.size() != 0) begin bad++; $display("FAIL bp_drain: valid_out got %0b want 0", bus.valid_out); end
    endtask

    task automatic test_stall();
        bus.ready_in = 1'b0; bus.valid_in = 1'b1; bus.sel_in = 2'd1;
        bus.d_in = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        step();
        for (int i = 0; i < 5; i++) begin
            bus.valid_in = 1'($urandom_range(0, 1));
            bus.sel_in = 2'($urandom_range(0, 2));
            bus.d_in = 48'({$urandom(), $urandom()});
            step();
            total++; if (bus.m_out !== 16'h0B0B || bus.valid_out !== 1'b1) begin bad++; $display("FAIL stall[%0d]: got %h/%0b want 0b0b/1", i, bus.m_out, bus.valid_out); end
        end
        bus.valid_in = 1'b0; bus.ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (mq.size() > 0) begin
                total++; if (bus.m_out !== mq[0]) begin bad++; $display("FAIL stall_drain[%0d]: got %h want %h", i, bus.m_out, mq[0]); end
            end
            step();
        end
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL stall_empty: valid_out got %0b want 0", bus.valid_out); end
    endtask

    task automatic test_bad_sel();
        bus.ready_in = 1'b1; bus.valid_in = 1'b1; bus.sel_in = 2'd3;
        bus.d_in = {16'h1234, 16'h5678, 16'h9ABC};
        step();
        total++; if (bus.valid_out !== 1'b1 || bus.m_out !== 16'h0000) begin bad++; $display("FAIL badsel_data: got %h/%0b want 0000/1", bus.m_out, bus.valid_out); end
        total++; if (bus.sel_err_out !== 1'b1) begin bad++; $display("FAIL badsel_flag: got %0b want 1", bus.sel_err_out); end
        for (int i = 0; i < 8; i++) begin
            bus.valid_in = 1'($urandom_range(0, 1));
            bus.ready_in = 1'($urandom_range(0, 1));
            bus.sel_in = 2'($urandom_range(0, 2));
            bus.d_in = 48'({$urandom(), $urandom()});
            step();
            total++; if (bus.sel_err_out !== 1'b1) begin bad++; $display("FAIL badsel_sticky[%0d]: got %0b want 1", i, bus.sel_err_out); end
            if (mq.size() > 0) begin
                total++; if (bus.m_out !== mq[0]) begin bad++; $display("FAIL badsel_follow[%0d]: got %h want %h", i, bus.m_out, mq[0]); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.valid_in = 1'($urandom_range(0, 3) != 0);
            bus.ready_in = 1'($urandom_range(0, 3) != 0);
            bus.sel_in = 2'($urandom_range(0, 3));
            bus.d_in = 48'({$urandom(), $urandom()});
            step();
            total++; if (bus.valid_out !== (mq.size() > 0)) begin bad++; $display("FAIL rand_valid[%0d]: got %0b want %0b", i, bus.valid_out, mq.size() > 0); end
            total++; if (bus.ready_out !== (mq.size() < 2)) begin bad++; $display("FAIL rand_ready[%0d]: got %0b want %0b", i, bus.ready_out, mq.size() < 2); end
            total++; if (bus.sel_err_out !== err_m) begin bad++; $display("FAIL rand_err[%0d]: got %0b want %0b", i, bus.sel_err_out, err_m); end
            if (mq.size() > 0) begin
                total++; if (bus.m_out !== mq[0]) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, bus.m_out, mq[0]); end
            end
        end
    endtask

    task automatic test_midop_reset();
        bus.ready_in = 1'b0; bus.valid_in = 1'b1; bus.sel_in = 2'd0;
        bus.d_in = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        step();
        step();
        total++; if (bus.ready_out !== 1'b0) begin bad++; $display("FAIL midrst_full: ready_out got %0b want 0", bus.ready_out); end
        rst = 1'b1; step();
        total++; if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin bad++; $display("FAIL midrst_out: valid %0b ready %0b want 0 1", bus.valid_out, bus.ready_out); end
        total++; if (bus.m_out !== 16'h0000 || bus.sel_err_out !== 1'b0) begin bad++; $display("FAIL midrst_vals: m_out %h err %0b want 0000 0", bus.m_out, bus.sel_err_out); end
        rst = 1'b0; bus.valid_in = 1'b0; bus.ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL midrst_after[%0d]: valid_out got %0b want 0", i, bus.valid_out); end
        end
    endtask

    initial begin
        bus.valid_in = 1'b0; bus.ready_in = 1'b0; bus.sel_in = 2'd0; bus.d_in = '0;
        err_m = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_bad_sel();
        test_random();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
